// File: rtl/unidade_es_param.sv
// Parametrised I/O unit: OUT runs a sequential double-dabble conversion onto
// seven-segment digits; IN stalls the core until a debounced confirm press.
module unidade_es_param #(
  parameter int DATA_W     = 32,
  parameter int IN_W       = 16,
  parameter int DIGITS     = 8,
  parameter int SIGNED     = 1,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            io_op,
  input  logic [DATA_W-1:0]     saida,
  input  logic [IN_W-1:0]       entrada,
  input  logic                  confirma,
  output logic [DATA_W-1:0]     dado_entrada,
  output logic                  trava,
  output logic [7*DIGITS-1:0]   displays,
  output logic                  ocupado
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(DEB_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    ESPERA_ENTRADA,
    LIBERA
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   bin;
  logic [BW-1:0]       bcd;
  logic [CW-1:0]       cnt;
  logic                neg;
  logic                ovf;
  logic                deb_level;
  logic [DW-1:0]       deb_cnt;

  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_next;
  logic [DATA_W-1:0]   bin_next;
  logic                ovf_next;
  logic [7*DIGITS-1:0] disp_next;
  int                  msd;

  logic                neg_in;
  logic [DATA_W-1:0]   mag_in;
  logic [DATA_W-1:0]   ext_s;
  logic [DATA_W-1:0]   ext_in;
  logic                deb_rise;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign neg_in = (SIGNED != 0) && saida[DATA_W-1];
  assign mag_in = neg_in ? (~saida + DATA_W'(1)) : saida;
  assign ext_s  = DATA_W'($signed(entrada));
  assign ext_in = (SIGNED != 0) ? ext_s : DATA_W'(entrada);

  // Fires on the edge where the debounced level is about to go high.
  assign deb_rise = !deb_level && confirma && (deb_cnt == DW'(DEB_CYCLES - 1));

  assign trava = ((io_op == 2'b01) || (io_op == 2'b10)) && (state != LIBERA) && !reset;

  // One double-dabble step: correct each nibble, then shift {bcd, bin} left.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    {bcd_next, bin_next} = {bcd_adj, bin} << 1;
    ovf_next = ovf | bcd_adj[BW-1];
  end

  always_comb begin
    msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_next[4*k +: 4] != 4'd0) msd = k;
    end
    disp_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k <= msd)                    disp_next[7*k +: 7] = seg7(bcd_next[4*k +: 4]);
      else if (neg && (k == msd + 1))  disp_next[7*k +: 7] = SEG_MINUS;
      else                             disp_next[7*k +: 7] = SEG_BLANK;
    end
    // Value too wide, or negative with no digit left for the sign.
    if (ovf_next || (neg && (msd == DIGITS - 1))) disp_next = {DIGITS{SEG_MINUS}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= OCIOSO;
      ocupado      <= 1'b0;
      bin          <= '0;
      bcd          <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
      ovf          <= 1'b0;
      deb_level    <= 1'b0;
      deb_cnt      <= '0;
      dado_entrada <= '0;
      displays     <= '1;
    end else begin
      // NOTE: all state here uses <= so every register sees pre-edge values.
      if (confirma == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        deb_level <= confirma;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      case (state)
        OCIOSO: begin
          if (io_op == 2'b10) begin
            bin     <= mag_in;
            neg     <= neg_in;
            bcd     <= '0;
            ovf     <= 1'b0;
            cnt     <= CW'(DATA_W);
            state   <= CONVERTE;
            ocupado <= 1'b1;
          end else if (io_op == 2'b01) begin
            state   <= ESPERA_ENTRADA;
            ocupado <= 1'b1;
          end
        end
        CONVERTE: begin
          bcd <= bcd_next;
          bin <= bin_next;
          ovf <= ovf_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            displays <= disp_next;
            state    <= LIBERA;
          end
        end
        ESPERA_ENTRADA: begin
          if (deb_rise) begin
            dado_entrada <= ext_in;
            state        <= LIBERA;
          end
        end
        LIBERA: begin
          state   <= OCIOSO;
          ocupado <= 1'b0;
        end
        default: begin
          state   <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_es_param.sv
// Self-checking bench for unidade_es_param: OUT table + random values against a
// decimal reference model, and IN sequences against a debounce window model.
module tb_unidade_es_param;

  localparam int DATA_W = 32;
  localparam int IN_W   = 16;
  localparam int DIGITS = 8;
  localparam int DEB    = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          io_op;
  logic [DATA_W-1:0]   saida;
  logic [IN_W-1:0]     entrada;
  logic                confirma;
  logic [DATA_W-1:0]   dado_entrada;
  logic                trava;
  logic [7*DIGITS-1:0] displays;
  logic                ocupado;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [31:0] val;
    logic [55:0] exp;
  } out_vec_t;

  out_vec_t tab [10];

  unidade_es_param #(
    .DATA_W(DATA_W), .IN_W(IN_W), .DIGITS(DIGITS), .SIGNED(1), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .io_op(io_op), .saida(saida),
    .entrada(entrada), .confirma(confirma), .dado_entrada(dado_entrada),
    .trava(trava), .displays(displays), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal rendering from plain integer arithmetic.
  function automatic logic [55:0] disp_model(input logic [31:0] v);
    longint sv, mag;
    bit neg;
    int nd;
    int dig [10];
    logic [55:0] r;
    sv  = longint'($signed(v));
    neg = sv < 0;
    mag = neg ? -sv : sv;
    nd  = 0;
    do begin
      dig[nd] = int'(mag % 10);
      mag = mag / 10;
      nd++;
    end while (mag != 0);
    if (nd > DIGITS || (neg && nd >= DIGITS)) return {DIGITS{7'h3F}};
    r = {DIGITS{7'h7F}};
    for (int k = 0; k < nd; k++) r[7*k +: 7] = seg_tab[dig[k]];
    if (neg) r[7*nd +: 7] = 7'h3F;
    return r;
  endfunction

  // Index of the first sample that completes DEB consecutive highs.
  function automatic int accept_index(input logic [7:0] pat, input int plen);
    bit ok;
    for (int i = DEB - 1; i <= plen + DEB; i++) begin
      ok = 1'b1;
      for (int j = i - DEB + 1; j <= i; j++) if ((j < plen) ? !pat[j] : 1'b0) ok = 1'b0;
      if (ok) return i;
    end
    return plen + DEB;
  endfunction

  task automatic do_out(input logic [31:0] v, input logic [55:0] exp, input bit chain,
                        input string name);
    int hi;
    @(negedge clock);
    io_op = 2'b10;
    saida = v;
    #1;
    hi = 0;
    while (trava === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clock);
      #1;
    end
    check({name, "_stall"}, hi, DATA_W + 1);
    check({name, "_disp"}, displays, exp);
    check({name, "_busy_libera"}, ocupado, 1);
    if (!chain) begin
      io_op = 2'b00;
      @(negedge clock);
      #1;
      check({name, "_idle"}, ocupado, 0);
    end
  endtask

  task automatic release_btn(input int n);
    repeat (n) begin
      @(negedge clock);
      confirma = 1'b0;
    end
  endtask

  task automatic do_in(input logic [15:0] val, input logic [7:0] pat, input int plen,
                       input bit chain, input string name);
    int hi, c;
    hi = 0;
    c  = 0;
    @(negedge clock);
    io_op   = 2'b01;
    entrada = val;
    while (1) begin
      confirma = (c < plen) ? pat[c] : 1'b1;
      #1;
      if (trava !== 1'b1 || c >= 60) break;
      hi++;
      c++;
      @(negedge clock);
    end
    check({name, "_stall"}, hi, accept_index(pat, plen) + 1);
    check({name, "_data"}, dado_entrada, {{(DATA_W-IN_W){val[IN_W-1]}}, val});
    if (!chain) begin
      io_op    = 2'b00;
      confirma = 1'b0;
    end
  endtask

  initial begin
    int held, n;
    logic [31:0] v;
    logic [7:0]  pat;

    tab[0] = '{32'd1234,       {{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}};
    tab[1] = '{32'hFFFF_FFFB,  {{6{7'h7F}}, 7'h3F, 7'h12}};
    tab[2] = '{32'd0,          {{7{7'h7F}}, 7'h40}};
    tab[3] = '{32'd100000000,  {8{7'h3F}}};
    tab[4] = '{32'hFF67_6980,  {8{7'h3F}}};
    tab[5] = '{32'd99999999,   {8{7'h10}}};
    tab[6] = '{32'hFF67_6981,  {7'h3F, {7{7'h10}}}};
    tab[7] = '{32'h8000_0000,  {8{7'h3F}}};
    tab[8] = '{32'hFFFF_FFFF,  {{6{7'h7F}}, 7'h3F, 7'h79}};
    tab[9] = '{32'd7,          {{7{7'h7F}}, 7'h78}};

    reset    = 1'b1;
    io_op    = 2'b10;
    saida    = '0;
    entrada  = '0;
    confirma = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_trava", trava, 0);
    check("rst_disp", displays, {DIGITS{7'h7F}});
    check("rst_busy", ocupado, 0);
    check("rst_data", dado_entrada, 0);
    @(negedge clock);
    reset = 1'b0;
    io_op = 2'b00;

    // Reserved opcode is a no-op.
    @(negedge clock);
    io_op = 2'b11;
    #1;
    check("op11_trava", trava, 0);
    @(negedge clock);
    #1;
    check("op11_idle", ocupado, 0);
    io_op = 2'b00;

    // Row 0 chains straight into row 1: no bubble after LIBERA.
    for (int i = 0; i < 10; i++)
      do_out(tab[i].val, tab[i].exp, (i == 0), $sformatf("out_tab%0d", i));

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = -$urandom_range(1, 9999999);
        default: v = (($urandom_range(0, 1) == 1) ? 32'd99999990 : -32'd10000010)
                     + $urandom_range(0, 20);
      endcase
      do_out(v, disp_model(v), $urandom_range(0, 1) == 1, $sformatf("out_rnd%0d", i));
    end
    io_op = 2'b00;

    // IN with bounce 1,0,1 then held; a second IN while still held must wait.
    release_btn(6);
    do_in(16'h8001, 8'b0000_0101, 3, 1'b1, "in_bounce");
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      confirma = 1'b1;
      #1;
      if (trava === 1'b1) held++;
    end
    check("in_held_stall", held, 10);
    check("in_held_data", dado_entrada, 32'hFFFF_8001);
    entrada = 16'h1234;
    held = 0;
    for (int c = 0; c < DEB; c++) begin
      @(negedge clock);
      confirma = 1'b0;
      #1;
      if (trava === 1'b1) held++;
    end
    check("in_release_stall", held, DEB);
    n = 0;
    while (1) begin
      @(negedge clock);
      confirma = 1'b1;
      #1;
      if (trava !== 1'b1 || n >= 20) break;
      n++;
    end
    check("in_repress_latency", n, DEB);
    check("in_repress_data", dado_entrada, 32'h0000_1234);
    io_op    = 2'b00;
    confirma = 1'b0;

    for (int i = 0; i < 6; i++) begin
      release_btn(6);
      pat = 8'($urandom);
      do_in(16'($urandom), pat, $urandom_range(0, 6), 1'b0, $sformatf("in_rnd%0d", i));
    end

    // Reset in the middle of an IN wait.
    release_btn(6);
    @(negedge clock);
    io_op = 2'b01;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    io_op = 2'b00;
    #1;
    check("rst_wait_busy", ocupado, 0);
    check("rst_wait_data", dado_entrada, 0);
    check("rst_wait_trava", trava, 0);

    // Reset during cycle 10 of an OUT conversion.
    do_out(32'd4321, disp_model(32'd4321), 1'b0, "out_pre_rst");
    @(negedge clock);
    io_op = 2'b10;
    saida = 32'd1234;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_conv_trava_during", trava, 0);
    @(negedge clock);
    reset = 1'b0;
    io_op = 2'b00;
    #1;
    check("rst_conv_busy", ocupado, 0);
    check("rst_conv_trava", trava, 0);
    check("rst_conv_disp", displays, {DIGITS{7'h7F}});
    do_out(32'd7, {{7{7'h7F}}, 7'h78}, 1'b0, "out_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_es_param.md
# unidade_es_param

Parametrised I/O unit for the KingProcessador core. It replaces the fixed 16-bit-in / 8-display I/O path with a configurable-width, multi-cycle unit.

- OUT instructions run a sequential binary-to-BCD conversion (double dabble) onto N seven-segment digits. The unit handles sign, leading-zero blanking and overflow.
- IN instructions stall the core until a debounced confirm-button press, then return the extended switch value.
- The unit sits beside the control unit and register bank. It drives the PC stall and the write-back data for IN.

## Interface

Parameters:
- DATA_W, 32, datapath width (≥ 8).
- IN_W, 16, switch input width (≤ DATA_W).
- DIGITS, 8, number of seven-segment digits (1..10).
- SIGNED, 1, 1 = two's-complement display and sign-extended IN; 0 = unsigned display and zero-extended IN.
- DEB_CYCLES, 50000, stable-level cycles required by the confirm debouncer (≥ 2).

Ports:
- clock, in, 1, single system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- io_op, in, 2, operation code: 00 none, 01 IN, 10 OUT, 11 reserved (treated as none).
- saida, in, DATA_W, value to display on OUT.
- entrada, in, IN_W, switch value read on IN.
- confirma, in, 1, raw confirm button, active-high, may bounce.
- dado_entrada, out, DATA_W, extended IN value, valid while trava=0 in LIBERA, held afterwards.
- trava, out, 1, PC/register-write stall request.
- displays, out, 7*DIGITS, segment codes: digit k occupies bits [7k+6:7k], digit 0 is rightmost. Active-low, bit order gfedcba.
- ocupado, out, 1, high in every state except OCIOSO.

## Operation

- FSM states: OCIOSO, CONVERTE, ESPERA_ENTRADA, LIBERA.
- OCIOSO, io_op=10:
  - capture the magnitude of saida (|saida| if SIGNED and saida is negative; the negative flag is latched);
  - clear the BCD register;
  - load counter = DATA_W;
  - go to CONVERTE.
- CONVERTE:
  - each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, bin} left by 1 and decrement the counter;
  - a 1 shifted out of the top nibble sets the overflow flag;
  - at counter 1→0, update the display register and go to LIBERA.
- OCIOSO, io_op=01: go to ESPERA_ENTRADA.
- ESPERA_ENTRADA:
  - on the debounced rising press, load dado_entrada = entrada extended to DATA_W (sign-extended if SIGNED, else zero-extended);
  - go to LIBERA.
- LIBERA: unconditionally go to OCIOSO after one cycle.
- trava = (io_op ∈ {01,10}) and state ≠ LIBERA and reset = 0. It is combinational, so trava is high in the same cycle the IN/OUT instruction is presented.
- Display encoding:
  - digit segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, 7-bit);
  - blank = 7F; minus = 3F;
  - leading zeros are blank; value 0 shows a single "0" on digit 0;
  - a negative value puts minus on the digit immediately left of the most significant nonzero digit.
- Overflow: all digits show 3F when any of these hold:
  - the overflow flag is set;
  - the value is negative and all DIGITS digits are needed (no room for the sign);
  - the value is -2^(DATA_W-1) and it does not fit.
- Debouncer:
  - a counter tracks how long confirma has held its current level;
  - the debounced level changes only after DEB_CYCLES equal consecutive samples;
  - exactly one acceptance per debounced low→high transition;
  - a press that is already high when ESPERA_ENTRADA is entered is not accepted; the button must be released and pressed again.
- Reset:
  - applies from any state, including mid-conversion and mid-wait;
  - state = OCIOSO, displays all 7F, dado_entrada = 0, BCD/overflow/counter cleared;
  - debounced level = 0, debounce counter = 0, trava = 0, ocupado = 0.

## Timing

- OUT presented at cycle 0 (state OCIOSO, trava=1):
  - cycles 1..DATA_W are CONVERTE, trava=1;
  - displays change at the edge ending cycle DATA_W;
  - cycle DATA_W+1 is LIBERA, trava=0;
  - total DATA_W+2 cycles.
- IN: trava stays high until the debounced press.
  - The debounced press is registered DEB_CYCLES cycles after confirma last went high.
  - The next cycle is LIBERA with trava=0 and dado_entrada valid.
- Back-to-back IO: an instruction presented in the cycle after LIBERA starts from OCIOSO with no bubble.
- The displays hold the last value until the next OUT completes or a reset occurs.

## Test plan

All scenarios use DATA_W=32, DIGITS=8, SIGNED=1, DEB_CYCLES=4.

- OUT 1234 → trava high for 33 cycles, low for 1 cycle. Digits 3..0 = 79, 24, 30, 19; digits 7..4 = 7F; ocupado low afterwards.
- OUT 0xFFFFFFFB (-5) → digit 0 = 12, digit 1 = 3F, rest 7F. OUT 0 → digit 0 = 40, rest 7F.
- OUT 100000000 → all digits 3F. OUT -10000000 (needs 8 digits + sign) → all digits 3F.
- IN with entrada = 8001:
  - confirma bouncing 1,0,1 then high ≥ 4 cycles → dado_entrada = FFFF8001, trava low exactly 1 cycle;
  - a second IN while confirma is still held is not accepted until confirma is low for 4 cycles and then pressed again.
- Reset for 1 cycle at cycle 10 of the OUT 1234 conversion → next cycle state OCIOSO, all displays 7F, trava=0. A following OUT 7 shows 78 on digit 0.
